// File: rtl/store_unit.sv
// Stage-3 data-memory write unit: registers one lane-aligned store and holds it on the bus until ack.
// Optional bus-timeout watchdog enabled by defining STORE_TIMEOUT_EN.
module store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        mem_wr_req_in,
  input  logic [1:0]  funct3_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic        misaligned_store_in,
  input  logic        trap_taken_in,
  input  logic        wr_ack_in,
  output logic [31:0] d_addr_out,
  output logic [31:0] data_out,
  output logic [3:0]  wr_mask_out,
  output logic        wr_req_out,
  output logic        stall_out,
  output logic        bus_err_out
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_nxt, data_nxt;
  logic [3:0]  mask_nxt;
  logic        req_nxt;
  logic        accept;
  logic        timeout_hit;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("store_unit: TIMEOUT_CYCLES must be in 2..255");
  end

`ifdef STORE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;

  // A late ack in the terminal cycle wins over the timeout.
  assign timeout_hit = (state == REQ) && !wr_ack_in && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wait_cnt    <= '0;
      bus_err_out <= 1'b0;
    end else begin
      bus_err_out <= timeout_hit;
      if (accept)
        wait_cnt <= '0;
      else if (state == REQ && !wr_ack_in)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_err_out = 1'b0;
`endif

  always_comb begin
    accept    = (state == IDLE) && mem_wr_req_in && !misaligned_store_in &&
                !trap_taken_in && (funct3_in != 2'b11);
    stall_out = accept || ((state == REQ) && !wr_ack_in && !timeout_hit);
    state_nxt = state;
    addr_nxt  = d_addr_out;
    data_nxt  = data_out;
    mask_nxt  = wr_mask_out;
    req_nxt   = wr_req_out;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
          addr_nxt  = {iadder_in[31:2], 2'b00};
          case (funct3_in)
            2'b00: begin
              data_nxt = {4{rs2_in[7:0]}};
              mask_nxt = 4'b0001 << iadder_in[1:0];
            end
            2'b01: begin
              data_nxt = {2{rs2_in[15:0]}};
              mask_nxt = iadder_in[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
              data_nxt = rs2_in;
              mask_nxt = 4'b1111;
            end
          endcase
        end
      end
      REQ: begin
        if (wr_ack_in || timeout_hit) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
          addr_nxt  = '0;
          data_nxt  = '0;
          mask_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state       <= IDLE;
      d_addr_out  <= '0;
      data_out    <= '0;
      wr_mask_out <= '0;
      wr_req_out  <= 1'b0;
    end else begin
      state       <= state_nxt;
      d_addr_out  <= addr_nxt;
      data_out    <= data_nxt;
      wr_mask_out <= mask_nxt;
      wr_req_out  <= req_nxt;
    end
  end

endmodule
